echo_path_generator: RTL and testbench

//  Far-end echo-path model: generates the lagged/echoed 16-bit signal (sig16b_lag) that the echo

---
 rtl/echo_path_generator.sv | 151 +++++++++++++++
 tb/tb_echo_path_generator.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/echo_path_generator.sv
// Far-end echo-path model: circular delay line, bulk delay, 4-tap Q1.15 FIR,
// near-end add and 16-bit saturation, one result per sampling cycle.
module echo_path_generator #(
   parameter int DEPTH = 64,
   parameter int DELAY = 4
) (
   input  logic        clk_operation,
   input  logic        rst,
   input  logic        enable,
   input  logic [12:0] sampling_cycle_counter,
   input  logic [15:0] sig16b,
   input  logic [15:0] near_end,
   input  logic        coef_we,
   input  logic [1:0]  coef_addr,
   input  logic [15:0] coef_data,
   output logic [15:0] sig16b_lag,
   output logic        ready,
   output logic        busy,
   output logic        overrun
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_CAPTURE, S_MAC0, S_MAC1, S_MAC2, S_MAC3, S_SAT
   } state_t;

   state_t             state_q, state_d;
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]        fill_q, fill_d;
   logic signed [33:0] acc_q, acc_d;
   logic [15:0]        near_q, near_d;
   logic [15:0]        coef_q [4];
   logic [15:0]        coef_d [4];
   logic [15:0]        snap_q [4];
   logic [15:0]        snap_d [4];
   logic [15:0]        lag_q, lag_d;
   logic               ready_q, ready_d;
   logic               busy_q, busy_d;
   logic               overrun_q, overrun_d;
   logic [12:0]        cnt_prev_q;
   logic               first_q;
   logic [15:0]        mem_q [DEPTH];

   logic               evt;
   logic [1:0]         mac_k;
   logic [AW-1:0]      rd_idx;
   logic signed [15:0] tap_x;
   logic signed [31:0] prod;
   logic signed [33:0] sum;

   // Counter parked at zero yields a single event: only a 0 following non-zero
   // (or the first cycle out of reset) counts.
   assign evt = enable && (sampling_cycle_counter == 13'd0) &&
                ((cnt_prev_q != 13'd0) || first_q);

   always_comb begin
      mac_k = 2'd0;
      case (state_q)
         S_MAC1:  mac_k = 2'd1;
         S_MAC2:  mac_k = 2'd2;
         S_MAC3:  mac_k = 2'd3;
         default: mac_k = 2'd0;
      endcase
      rd_idx = wr_ptr_q - AW'(DELAY) - AW'(mac_k);
      tap_x  = ((DELAY + int'(mac_k)) <= int'(fill_q)) ? $signed(mem_q[rd_idx]) : 16'sd0;
      prod   = $signed(snap_q[mac_k]) * tap_x;
      sum    = (acc_q >>> 15) + 34'($signed(near_q));
   end

   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      fill_d    = fill_q;
      acc_d     = acc_q;
      near_d    = near_q;
      coef_d    = coef_q;
      snap_d    = snap_q;
      lag_d     = lag_q;
      ready_d   = 1'b0;
      overrun_d = overrun_q | (evt & (state_q != S_IDLE));
      if (coef_we) coef_d[coef_addr] = coef_data;
      case (state_q)
         S_IDLE: if (evt) state_d = S_CAPTURE;
         S_CAPTURE: begin
            near_d  = near_end;
            snap_d  = coef_q;
            acc_d   = '0;
            state_d = S_MAC0;
         end
         S_MAC0: begin acc_d = acc_q + 34'(prod); state_d = S_MAC1; end
         S_MAC1: begin acc_d = acc_q + 34'(prod); state_d = S_MAC2; end
         S_MAC2: begin acc_d = acc_q + 34'(prod); state_d = S_MAC3; end
         S_MAC3: begin acc_d = acc_q + 34'(prod); state_d = S_SAT;  end
         S_SAT: begin
            if (sum > 34'sd32767)       lag_d = 16'h7FFF;
            else if (sum < -34'sd32768) lag_d = 16'h8000;
            else                        lag_d = sum[15:0];
            ready_d  = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (fill_q != (AW+1)'(DEPTH)) fill_d = fill_q + 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_operation) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         fill_q     <= '0;
         acc_q      <= '0;
         near_q     <= '0;
         coef_q     <= '{default: '0};
         snap_q     <= '{default: '0};
         lag_q      <= '0;
         ready_q    <= 1'b0;
         busy_q     <= 1'b0;
         overrun_q  <= 1'b0;
         cnt_prev_q <= '0;
         first_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         fill_q     <= fill_d;
         acc_q      <= acc_d;
         near_q     <= near_d;
         coef_q     <= coef_d;
         snap_q     <= snap_d;
         lag_q      <= lag_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         overrun_q  <= overrun_d;
         cnt_prev_q <= sampling_cycle_counter;
         first_q    <= 1'b0;
      end
   end

   // Delay-line storage is left uninitialised; fill keeps stale words out of the taps.
   always_ff @(posedge clk_operation) begin
      if (rst && (state_q == S_CAPTURE)) mem_q[wr_ptr_q] <= sig16b;
   end

   assign sig16b_lag = lag_q;
   assign ready      = ready_q;
   assign busy       = busy_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_echo_path_generator.sv
// Bench for echo_path_generator: three instances (DELAY 4, 0, 60) share stimulus and
// are checked against a sample-history model of the echo path.
module tb_echo_path_generator;

   localparam int DL [3] = '{4, 0, 60};

   logic        clk = 1'b0;
   logic        rst, enable, cwe;
   logic [12:0] cnt;
   logic [15:0] sig, ne, cdata;
   logic [1:0]  caddr;
   logic [15:0] lag [3];
   logic        rdy [3];
   logic        bsy [3];
   logic        ovr [3];

   int errors = 0;
   int checks = 0;
   int hist[$];
   int coef_m [4];
   int rcount;
   logic [15:0] exp_v [3];

   always #5 clk = ~clk;

   echo_path_generator #(.DEPTH(64), .DELAY(4)) u_d4 (
      .clk_operation(clk), .rst(rst), .enable(enable), .sampling_cycle_counter(cnt),
      .sig16b(sig), .near_end(ne), .coef_we(cwe), .coef_addr(caddr), .coef_data(cdata),
      .sig16b_lag(lag[0]), .ready(rdy[0]), .busy(bsy[0]), .overrun(ovr[0]));
   echo_path_generator #(.DEPTH(64), .DELAY(0)) u_d0 (
      .clk_operation(clk), .rst(rst), .enable(enable), .sampling_cycle_counter(cnt),
      .sig16b(sig), .near_end(ne), .coef_we(cwe), .coef_addr(caddr), .coef_data(cdata),
      .sig16b_lag(lag[1]), .ready(rdy[1]), .busy(bsy[1]), .overrun(ovr[1]));
   echo_path_generator #(.DEPTH(64), .DELAY(60)) u_d60 (
      .clk_operation(clk), .rst(rst), .enable(enable), .sampling_cycle_counter(cnt),
      .sig16b(sig), .near_end(ne), .coef_we(cwe), .coef_addr(caddr), .coef_data(cdata),
      .sig16b_lag(lag[2]), .ready(rdy[2]), .busy(bsy[2]), .overrun(ovr[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   function automatic int s16(input logic [15:0] v);
      return int'($signed(v));
   endfunction

   // y[n] = floor(sum_k c_k * x[n-D-k] / 2^15) + near, samples before reset count as 0
   function automatic logic [15:0] expect_out(input int d, input int near);
      longint acc = 0;
      longint q;
      int n = hist.size() - 1;
      for (int k = 0; k < 4; k++) begin
         int j = n - d - k;
         if (j >= 0) acc += longint'(coef_m[k]) * longint'(hist[j]);
      end
      q = acc / 32768;
      if (acc < 0 && (acc % 32768) != 0) q = q - 1;
      q = q + near;
      if (q > 32767)  q = 32767;
      if (q < -32768) q = -32768;
      return 16'(q);
   endfunction

   task automatic do_reset();
      @(negedge clk); rst = 1'b0; cwe = 1'b0;
      @(negedge clk); rst = 1'b1;
      hist.delete();
      coef_m = '{0, 0, 0, 0};
   endtask

   task automatic write_coef(input logic [1:0] a, input logic [15:0] d);
      @(negedge clk); cwe = 1'b1; caddr = a; cdata = d;
      @(negedge clk); cwe = 1'b0;
      coef_m[a] = s16(d);
   endtask

   task automatic do_event(input logic [15:0] s, input logic [15:0] n_e,
                           input bit mid_wr = 1'b0, input logic [1:0] wa = 2'd0,
                           input logic [15:0] wd = 16'd0);
      @(negedge clk); sig = s; ne = n_e; cnt = 13'd0;
      hist.push_back(s16(s));
      for (int u = 0; u < 3; u++) exp_v[u] = expect_out(DL[u], s16(n_e));
      @(posedge clk);
      @(negedge clk); cnt = 13'd1;
      for (int i = 1; i <= 6; i++) begin
         @(posedge clk); #1;
         for (int u = 0; u < 3; u++) begin
            chk($sformatf("ready[%0d] cyc%0d", u, i), 32'(rdy[u]), 32'(i == 6));
            chk($sformatf("busy[%0d] cyc%0d", u, i), 32'(bsy[u]), 32'(i < 6));
         end
         if (mid_wr && i == 2) begin cwe = 1'b1; caddr = wa; cdata = wd; end
         if (mid_wr && i == 3) cwe = 1'b0;
      end
      if (mid_wr) coef_m[wa] = s16(wd);
      for (int u = 0; u < 3; u++) chk($sformatf("lag[%0d]", u), 32'(lag[u]), 32'(exp_v[u]));
      repeat (2) @(negedge clk);
   endtask

   initial begin
      rst = 1'b0; enable = 1'b1; cwe = 1'b0; cnt = 13'd1;
      sig = '0; ne = '0; cdata = '0; caddr = '0;
      coef_m = '{0, 0, 0, 0};
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      #1;
      for (int u = 0; u < 3; u++) begin
         chk("reset lag", 32'(lag[u]), 32'h0);
         chk("reset ready", 32'(rdy[u]), 32'h0);
         chk("reset busy", 32'(bsy[u]), 32'h0);
         chk("reset overrun", 32'(ovr[u]), 32'h0);
      end

      // impulse through the DELAY=4 path
      write_coef(2'd0, 16'h4000);
      for (int n = 0; n < 6; n++) begin
         do_event((n == 0) ? 16'h7FFF : 16'h0000, 16'h0000);
         if (n == 4) chk("t1 impulse", 32'(lag[0]), 32'h3FFF);
      end

      // fill guard
      do_reset();
      write_coef(2'd1, 16'h4000);
      do_event(16'd1000, 16'h0000);
      chk("t2 first", 32'(lag[1]), 32'h0);
      do_event(16'd0, 16'h0000);
      chk("t2 second", 32'(lag[1]), 32'd500);

      // saturation both ways
      do_reset();
      for (int k = 0; k < 4; k++) write_coef(2'(k), 16'h7FFF);
      repeat (4) do_event(16'h7FFF, 16'h0000);
      chk("t3 pos sat", 32'(lag[1]), 32'h7FFF);
      repeat (4) do_event(16'h8000, 16'h0000);
      chk("t3 neg sat", 32'(lag[1]), 32'h8000);

      // near-end add and truncation
      do_reset();
      do_event(16'h0000, 16'hFFFB);
      chk("t4 near only", 32'(lag[1]), 32'hFFFB);
      write_coef(2'd0, 16'h7FFF);
      do_event(16'd10, 16'd5);
      chk("t4 trunc", 32'(lag[1]), 32'd14);

      // counter parked at zero gives one event
      @(negedge clk); cnt = 13'd0; sig = 16'd1234; ne = 16'd7;
      hist.push_back(1234);
      for (int u = 0; u < 3; u++) exp_v[u] = expect_out(DL[u], 7);
      rcount = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (rdy[0]) rcount++;
         if (i == 19) cnt = 13'd1;
      end
      chk("t5 hold ready count", 32'(rcount), 32'd1);
      for (int u = 0; u < 3; u++) chk("t5 hold lag", 32'(lag[u]), 32'(exp_v[u]));
      chk("t5 no overrun on hold", 32'(ovr[0]), 32'h0);

      // re-armed event while busy is dropped and flagged
      @(negedge clk); cnt = 13'd0; sig = 16'hF00D; ne = 16'h0000;
      hist.push_back(s16(16'hF00D));
      for (int u = 0; u < 3; u++) exp_v[u] = expect_out(DL[u], 0);
      @(negedge clk); cnt = 13'd1;
      @(negedge clk);
      @(negedge clk); cnt = 13'd0;
      @(negedge clk); cnt = 13'd1;
      rcount = 0;
      repeat (10) begin @(posedge clk); #1; if (rdy[0]) rcount++; end
      chk("t5 dropped ready count", 32'(rcount), 32'd1);
      for (int u = 0; u < 3; u++) begin
         chk("t5 overrun set", 32'(ovr[u]), 32'h1);
         chk("t5 dropped lag", 32'(lag[u]), 32'(exp_v[u]));
      end
      do_event(16'd321, 16'h0000);
      chk("t5 overrun sticky", 32'(ovr[2]), 32'h1);

      // reset lands mid-computation
      @(negedge clk); cnt = 13'd0; sig = 16'h1111;
      @(negedge clk); cnt = 13'd1;
      @(negedge clk);
      @(negedge clk); rst = 1'b0;
      @(negedge clk); rst = 1'b1;
      hist.delete();
      coef_m = '{0, 0, 0, 0};
      rcount = 0;
      repeat (8) begin @(posedge clk); #1; if (rdy[0] || rdy[1] || rdy[2]) rcount++; end
      chk("t6 no ready", 32'(rcount), 32'd0);
      for (int u = 0; u < 3; u++) begin
         chk("t6 lag cleared", 32'(lag[u]), 32'h0);
         chk("t6 busy cleared", 32'(bsy[u]), 32'h0);
         chk("t6 overrun cleared", 32'(ovr[u]), 32'h0);
      end
      write_coef(2'd1, 16'h6000);
      write_coef(2'd2, 16'hA000);
      write_coef(2'd3, 16'h2000);
      for (int n = 0; n < 5; n++) do_event(16'($urandom), 16'($urandom_range(0, 200)));

      // events ignored while disabled
      enable = 1'b0;
      @(negedge clk); cnt = 13'd0;
      @(negedge clk); cnt = 13'd1;
      rcount = 0;
      repeat (8) begin @(posedge clk); #1; if (rdy[0]) rcount++; end
      chk("disabled no ready", 32'(rcount), 32'd0);
      enable = 1'b1;

      // ramp across the write-pointer wrap
      do_reset();
      write_coef(2'd0, 16'h4000);
      for (int n = 0; n < 200; n++) begin
         do_event(16'(n * 37 - 3000), 16'h0000);
         if (n == 150) chk("wrap d60 n150", 32'(lag[2]), 32'd165);
      end

      // random coefficients and samples, occasional write during MAC
      do_reset();
      for (int k = 0; k < 4; k++) write_coef(2'(k), 16'($urandom));
      for (int n = 0; n < 40; n++)
         do_event(16'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0),
                  2'($urandom_range(0, 3)), 16'($urandom));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
